adder_result_buffer: RTL and testbench
======================================

# adder_result_buffer

Elastic result buffer placed directly downstream of the 9-bit adder stage. It captures every 10-bit sum presented with a valid strobe into a small FIFO. It re-presents the sums to the consumer over a valid/ready handshake, which decouples the adder's free-running output from consumers that stall. Sums that arrive while the buffer is full are dropped and reported through a sticky overflow flag.

## Interface
- DATA_W, 10, width of each stored sum (9-bit + 9-bit operands plus carry)
- DEPTH, 8, number of entries; power of two, minimum 2
- LVL_W, $clog2(DEPTH)+1, width of the occupancy count
- CNT_W, 16, width of the drop counter (used only with the configuration macro)

Ports:
- clk  in  1  clock; all state updates on its rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_data  in  DATA_W  sum from the adder stage
- in_valid  in  1  in_data is valid this cycle; no backpressure toward the producer
- out_data  out  DATA_W  head-of-queue sum; forced to 0 when the buffer is empty
- out_valid  out  1  buffer is not empty
- out_ready  in  1  consumer accepts the head entry this cycle
- level  out  LVL_W  current occupancy, 0..DEPTH
- full  out  1  level == DEPTH
- empty  out  1  level == 0
- overflow  out  1  sticky; set when a sum is dropped
- ovf_clr  in  1  single-cycle pulse that clears overflow (and drop_cnt)
- drop_cnt  out  CNT_W  number of dropped sums; present only with ADDER_RESULT_BUFFER_DROP_CNT_EN

## Operation
- Storage: circular buffer of DEPTH entries with wr_ptr/rd_ptr of $clog2(DEPTH) bits. Pointers wrap from DEPTH-1 to 0. Occupancy is held in the registered level.
- Pop: occurs when out_valid && out_ready. rd_ptr advances and level decrements.
- Push: occurs when in_valid && (!full || pop). Data is written at wr_ptr, wr_ptr advances and level increments.
- Simultaneous push and pop:
  - Both take effect and level is unchanged.
  - When full, the push is accepted because the pop frees the slot in the same cycle.
  - When empty, the push is accepted, no pop occurs (out_valid=0), and there is no bypass.
- Drop: in_valid && full && !pop. The data is discarded, pointers and level are unchanged, and overflow is set to 1.
- ovf_clr:
  - Clears overflow on the next edge.
  - If a drop occurs in the same cycle, the drop wins: overflow=1 after the edge.
- out_data is undefined-free: it equals mem[rd_ptr] when !empty and 0 when empty.
- Stored data is passed through unmodified; the block does no arithmetic on the data.
- Reset values:
  - out_valid=0, out_data=0, level=0, full=0, empty=1, overflow=0, drop_cnt=0.
  - Pointers are 0. Memory contents need not be reset.
- Reset mid-operation: all queued entries are discarded immediately (asynchronous), and outputs return to their reset values within the same cycle.

## Timing
- Write-to-output latency is one cycle. A push at edge N gives out_valid=1 and out_data=that sum from edge N onward, provided the buffer was empty.
- level, full, empty and overflow are registered and update on the edge following the triggering event.
- out_data/out_valid change only on clock edges or reset; there is no combinational path from in_* to out_*.
- The only combinational path from out_ready is into the internal pop/push decision; it does not reach any output.
- Sustained throughput is one push and one pop per cycle.

## Configuration
- ADDER_RESULT_BUFFER_DROP_CNT_EN defined:
  - The drop_cnt port and counter are present.
  - drop_cnt increments by 1 on every drop and saturates at 2^CNT_W-1.
  - ovf_clr resets it to 0; a drop in the same cycle as the clear yields drop_cnt=1.
- Undefined: no drop_cnt port and no counter logic. The overflow flag behaves identically in both builds.

## Test plan
- Reset, then push 0x1FF+0x1FF=0x3FE with out_ready=0 -> after one edge out_valid=1, out_data=0x3FE, level=1, empty=0.
- Push sums 1..8 with out_ready=0 -> full=1, level=8. Then drain with out_ready=1 -> outputs 1..8 in order, then empty=1, out_data=0.
- Full buffer, push 0x055 with out_ready=0 for 3 cycles -> level stays 8, overflow=1, drop_cnt=3 (macro on). The 0x055 never appears at the output.
- Full buffer, push 0x100 with out_ready=1 in the same cycle -> level stays 8, no overflow, and 0x100 emerges eighth after the current head.
- Overflow set, pulse ovf_clr together with a new drop -> overflow=1, drop_cnt=1. Pulse ovf_clr alone -> overflow=0, drop_cnt=0.
- Fill with 5 entries, assert rst_n=0 mid-cycle -> immediately level=0, out_valid=0, out_data=0. After release, the first push appears with one-cycle latency.

Source files
------------

// File: rtl/adder_result_buffer.sv
// adder_result_buffer
//   Elastic FIFO sitting behind the 9-bit adder stage. Every sum presented
//   with in_valid is captured (no backpressure to the producer) and replayed
//   to the consumer over a valid/ready handshake. Sums arriving while the
//   buffer is full and not draining are dropped and flagged via a sticky
//   overflow bit.
//
//   Optional feature macro: ADDER_RESULT_BUFFER_DROP_CNT_EN
//     When defined, a saturating drop counter is exposed on drop_cnt.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_data    in   [DATA_W] sum from the adder
//   in_valid   in   in_data valid this cycle
//   out_data   out  [DATA_W] head entry, 0 while empty
//   out_valid  out  buffer not empty
//   out_ready  in   consumer takes the head entry this cycle
//   level      out  [LVL_W] occupancy 0..DEPTH
//   full       out  level == DEPTH
//   empty      out  level == 0
//   overflow   out  sticky drop indicator
//   ovf_clr    in   pulse clearing overflow (and drop_cnt)
//   drop_cnt   out  [CNT_W] saturating drop count (macro builds only)
module adder_result_buffer #(
  parameter int DATA_W = 10,
  parameter int DEPTH  = 8,
  parameter int LVL_W  = $clog2(DEPTH) + 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LVL_W-1:0]  level,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  input  logic              ovf_clr
`ifdef ADDER_RESULT_BUFFER_DROP_CNT_EN
  ,
  output logic [CNT_W-1:0]  drop_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [LVL_W-1:0]  r_level;
  logic              r_overflow;

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign w_full  = (r_level == LVL_W'(DEPTH));
  assign w_empty = (r_level == '0);

  // out_ready only feeds this decision; a pop frees a slot so a full buffer
  // can still accept a push in the same cycle.
  assign w_pop  = !w_empty && out_ready;
  assign w_push = in_valid && (!w_full || w_pop);
  assign w_drop = in_valid && w_full && !w_pop;

  // Data storage: no reset needed, reads are masked by empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  // Control state: pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // A drop in the same cycle as a clear wins so no drop goes unreported.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (ovf_clr) begin
      r_overflow <= 1'b0;
    end
  end

`ifdef ADDER_RESULT_BUFFER_DROP_CNT_EN
  logic [CNT_W-1:0] r_drop_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_cnt <= '0;
    end else if (ovf_clr) begin
      r_drop_cnt <= w_drop ? CNT_W'(1) : '0;
    end else if (w_drop && (r_drop_cnt != '1)) begin
      r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  assign drop_cnt = r_drop_cnt;
`endif

  assign out_data  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign out_valid = !w_empty;
  assign level     = r_level;
  assign full      = w_full;
  assign empty     = w_empty;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_adder_result_buffer.sv
module tb_adder_result_buffer;
  localparam int DATA_W = 10;
  localparam int DEPTH  = 8;
  localparam int LVL_W  = $clog2(DEPTH) + 1;
  localparam int CNT_W  = 16;

  logic              clk;
  logic              rst_n;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic [LVL_W-1:0]  level;
  logic              full;
  logic              empty;
  logic              overflow;
  logic              ovf_clr;
`ifdef ADDER_RESULT_BUFFER_DROP_CNT_EN
  logic [CNT_W-1:0]  drop_cnt;
`endif

  adder_result_buffer #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .LVL_W(LVL_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .level(level), .full(full), .empty(empty), .overflow(overflow),
    .ovf_clr(ovf_clr)
`ifdef ADDER_RESULT_BUFFER_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a queue of pending sums plus overflow/drop state.
  int m_q[$];
  bit m_ovf;
  int m_cnt;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ovf = 1'b0;
    m_cnt = 0;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".level"}, int'(level), m_q.size());
    chk({tag, ".out_valid"}, int'(out_valid), (m_q.size() > 0) ? 1 : 0);
    chk({tag, ".out_data"}, int'(out_data), (m_q.size() > 0) ? m_q[0] : 0);
    chk({tag, ".full"}, int'(full), (m_q.size() == DEPTH) ? 1 : 0);
    chk({tag, ".empty"}, int'(empty), (m_q.size() == 0) ? 1 : 0);
    chk({tag, ".overflow"}, int'(overflow), int'(m_ovf));
`ifdef ADDER_RESULT_BUFFER_DROP_CNT_EN
    chk({tag, ".drop_cnt"}, int'(drop_cnt), m_cnt);
`endif
  endtask

  // One clock: drive inputs, advance model at the edge, compare #1 later.
  task automatic step(input bit v, input int d, input bit r, input bit c,
                      input string tag);
    bit pop, push, drop;
    in_valid  = v;
    in_data   = DATA_W'(d);
    out_ready = r;
    ovf_clr   = c;
    @(posedge clk);
    pop  = (m_q.size() > 0) && r;
    push = v && ((m_q.size() < DEPTH) || pop);
    drop = v && !push;
    if (pop) void'(m_q.pop_front());
    if (push) m_q.push_back(d);
    if (c) begin
      m_ovf = drop;
      m_cnt = drop ? 1 : 0;
    end else if (drop) begin
      m_ovf = 1'b1;
      if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
    end
    #1;
    check_model(tag);
  endtask

  typedef struct {
    bit v; int d; bit r; bit c;
    int e_level; bit e_valid; int e_data; bit e_ovf;
  } vec_t;

  vec_t vecs[7];

  initial begin
    // Hand-derived from reset: push 3FE, push/pop mix, drain, no-bypass push.
    vecs[0] = '{1, 'h3FE, 0, 0, 1, 1, 'h3FE, 0};
    vecs[1] = '{1, 'h001, 1, 0, 1, 1, 'h001, 0};
    vecs[2] = '{1, 'h002, 0, 0, 2, 1, 'h001, 0};
    vecs[3] = '{0, 'h000, 1, 0, 1, 1, 'h002, 0};
    vecs[4] = '{0, 'h000, 1, 0, 0, 0, 'h000, 0};
    vecs[5] = '{0, 'h000, 1, 0, 0, 0, 'h000, 0};
    vecs[6] = '{1, 'h0AA, 1, 0, 1, 1, 'h0AA, 0};

    rst_n = 1'b0; in_valid = 0; in_data = '0; out_ready = 0; ovf_clr = 0;
    model_reset();
    #12;
    chk("reset.level", int'(level), 0);
    chk("reset.out_valid", int'(out_valid), 0);
    chk("reset.out_data", int'(out_data), 0);
    chk("reset.empty", int'(empty), 1);
    chk("reset.full", int'(full), 0);
    chk("reset.overflow", int'(overflow), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      step(vecs[i].v, vecs[i].d, vecs[i].r, vecs[i].c, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d.tlevel", i), int'(level), vecs[i].e_level);
      chk($sformatf("vec%0d.tvalid", i), int'(out_valid), int'(vecs[i].e_valid));
      chk($sformatf("vec%0d.tdata", i), int'(out_data), vecs[i].e_data);
      chk($sformatf("vec%0d.tovf", i), int'(overflow), int'(vecs[i].e_ovf));
    end
    step(0, 0, 1, 0, "drain0");

    // Fill 1..8 with no consumer.
    for (int i = 1; i <= 8; i++) step(1, i, 0, 0, "fill");
    chk("fill.full", int'(full), 1);
    chk("fill.level", int'(level), 8);

    // Three drops of 0x055.
    for (int i = 0; i < 3; i++) step(1, 'h055, 0, 0, "drop");
    chk("drop.level", int'(level), 8);
    chk("drop.overflow", int'(overflow), 1);
`ifdef ADDER_RESULT_BUFFER_DROP_CNT_EN
    chk("drop.cnt", int'(drop_cnt), 3);
`endif

    // Push while full and popping: accepted.
    step(1, 'h100, 1, 0, "fullpp");
    chk("fullpp.level", int'(level), 8);
    chk("fullpp.head", int'(out_data), 2);

    // Clear together with a drop: drop wins.
    step(1, 'h077, 0, 1, "clrdrop");
    chk("clrdrop.overflow", int'(overflow), 1);
`ifdef ADDER_RESULT_BUFFER_DROP_CNT_EN
    chk("clrdrop.cnt", int'(drop_cnt), 1);
`endif
    step(0, 0, 0, 1, "clr");
    chk("clr.overflow", int'(overflow), 0);
`ifdef ADDER_RESULT_BUFFER_DROP_CNT_EN
    chk("clr.cnt", int'(drop_cnt), 0);
`endif

    // Drain: expect 2..8 then 0x100; 0x055/0x077 never seen.
    for (int i = 0; i < 8; i++) begin
      chk("drain.order", int'(out_data), (i < 7) ? i + 2 : 'h100);
      step(0, 0, 1, 0, "drain");
    end
    chk("drain.empty", int'(empty), 1);
    chk("drain.out_data", int'(out_data), 0);

    // Five entries, then asynchronous reset mid-cycle.
    for (int i = 0; i < 5; i++) step(1, 'h10 + i, 0, 0, "pre_rst");
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst.level", int'(level), 0);
    chk("arst.out_valid", int'(out_valid), 0);
    chk("arst.out_data", int'(out_data), 0);
    chk("arst.empty", int'(empty), 1);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 'h2C5, 0, 0, "post_rst");
    chk("post_rst.data", int'(out_data), 'h2C5);

    // Randomised traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 3) != 0), $urandom_range(0, 1023),
           ($urandom_range(0, 2) != 0) ^ (n[9]), ($urandom_range(0, 40) == 0),
           "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
